// File: rtl/led_pkg.sv
// Shared constants, FSM encoding and pixel-address helpers for the LED frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    localparam int FB_ROWS = 16;
    localparam int FB_COLS = 16;
    localparam int FB_BITS = FB_ROWS * FB_COLS;

    localparam int ADDR_ROW_MSB = 7;
    localparam int ADDR_ROW_LSB = 4;
    localparam int ADDR_COL_MSB = 3;
    localparam int ADDR_COL_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

    // Row-major bit index r*16+c is just the row and column fields concatenated.
    function automatic logic [7:0] pix_index(input logic [7:0] addr);
        return {addr[ADDR_ROW_MSB:ADDR_ROW_LSB], addr[ADDR_COL_MSB:ADDR_COL_LSB]};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; priority flips to the other requester after every grant.
// Latency: grant is combinational in the request cycle; pointer updates on the grant edge.
// Backpressure: en=0 forces gnt=0; losing requester must hold req until granted.
module rr_arbiter2 (
    input  logic       system_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered 16x16 framebuffer with arbitrated pixel writes, row clear and frame-aligned swap.
// Latency: write lands in back buffer on the grant edge; back->front copy on the next frame boundary.
// Backpressure: gnt is withheld during a clear or a clear-start cycle; requesters hold until granted.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [7:0]         addr0,
    input  logic [7:0]         addr1,
    input  logic               data0,
    input  logic               data1,
    output logic [1:0]         gnt,
    input  logic               clear,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               busy,
    output logic               scan_tick,
    output logic [3:0]         scan_row,
    output logic [FB_BITS-1:0] front_fb
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         scan_row_q, scan_row_d;
    fsm_state_t         state_q, state_d;
    logic [3:0]         clr_row_q, clr_row_d;
    logic [FB_BITS-1:0] back_q, back_d;
    logic [FB_BITS-1:0] front_q, front_d;
    logic               swap_pend_q, swap_pend_d;
    logic               swap_done_q, swap_done_d;

    logic tick;
    logic frame_bnd;
    logic arb_en;
    logic swap_fire;

    rr_arbiter2 u_arb (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .en         (arb_en),
        .req        (req),
        .gnt        (gnt)
    );

    // Scan timing runs freely, independent of the FSM.
    always_comb begin
        tick       = (div_q == DIV_MAX);
        div_d      = tick ? '0 : div_q + 1'b1;
        scan_row_d = tick ? scan_row_q + 4'd1 : scan_row_q;
        frame_bnd  = tick && (scan_row_q == 4'(FB_ROWS - 1));
    end

    always_comb begin
        arb_en    = (state_q == IDLE) && !clear;
        state_d   = state_q;
        clr_row_d = clr_row_q;
        back_d    = back_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d   = CLEAR;
                    clr_row_d = 4'd0;
                end else if (gnt[0]) begin
                    back_d[pix_index(addr0)] = data0;
                end else if (gnt[1]) begin
                    back_d[pix_index(addr1)] = data1;
                end
            end
            CLEAR: begin
                back_d[{clr_row_q, 4'b0000} +: FB_COLS] = '0;
                clr_row_d = clr_row_q + 4'd1;
                if (clr_row_q == 4'(FB_ROWS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Copy uses back_q, so a write granted on the boundary cycle misses this frame.
    always_comb begin
        swap_fire   = frame_bnd && (swap_pend_q || swap_req) && (state_q == IDLE);
        front_d     = swap_fire ? back_q : front_q;
        swap_pend_d = (swap_pend_q || swap_req) && !swap_fire;
        swap_done_d = swap_fire;
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            scan_row_q  <= '0;
            state_q     <= IDLE;
            clr_row_q   <= '0;
            back_q      <= '0;
            front_q     <= '0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            scan_row_q  <= scan_row_d;
            state_q     <= state_d;
            clr_row_q   <= clr_row_d;
            back_q      <= back_d;
            front_q     <= front_d;
            swap_pend_q <= swap_pend_d;
            swap_done_q <= swap_done_d;
        end
    end

    assign scan_tick    = tick;
    assign scan_row     = scan_row_q;
    assign busy         = (state_q == CLEAR);
    assign swap_pending = swap_pend_q;
    assign swap_done    = swap_done_q;
    assign front_fb     = front_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Randomized and directed bench for led_frame_scheduler against a cycle-count based frame model.
module tb_led_frame_scheduler;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [7:0]   addr0, addr1;
    logic         data0, data1, clear, swap_req;
    logic [1:0]   gnt;
    logic         swap_pending, swap_done, busy, scan_tick;
    logic [3:0]   scan_row;
    logic [255:0] front_fb;

    always #5 clk = ~clk;

    led_frame_scheduler #(.SCAN_DIV(D)) dut (
        .system_clk   (clk),
        .rst_n        (rst_n),
        .req          (req),
        .addr0        (addr0),
        .addr1        (addr1),
        .data0        (data0),
        .data1        (data1),
        .gnt          (gnt),
        .clear        (clear),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .busy         (busy),
        .scan_tick    (scan_tick),
        .scan_row     (scan_row),
        .front_fb     (front_fb)
    );

    int checks   = 0;
    int failures = 0;

    // Model: time is a cycle count since reset release; clear is a countdown of rows left.
    int           cyc;
    int           clr_left;
    bit           mptr;
    bit           mpend, mdone;
    logic [255:0] mback, mfront;
    logic [1:0]   e_gnt;
    logic         e_tick;
    logic [3:0]   e_row;

    logic [1:0]   s_gnt;
    logic         s_tick, s_busy, s_done;
    logic [3:0]   s_row;
    logic [255:0] s_front;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; clr_left = 0; mptr = 1'b0; mpend = 1'b0; mdone = 1'b0;
        mback = '0; mfront = '0;
    endtask

    task automatic model_expect();
        e_tick = ((cyc % D) == D - 1);
        e_row  = 4'((cyc / D) % 16);
        if (clr_left > 0 || clear) e_gnt = 2'b00;
        else if (req == 2'b11)     e_gnt = mptr ? 2'b10 : 2'b01;
        else                       e_gnt = req;
    endtask

    task automatic check();
        model_expect();
        s_gnt = gnt; s_tick = scan_tick; s_row = scan_row;
        s_busy = busy; s_done = swap_done; s_front = front_fb;
        chk("gnt", gnt, e_gnt);
        chk("scan_tick", scan_tick, e_tick);
        chk("scan_row", scan_row, e_row);
        chk("busy", busy, clr_left > 0);
        chk("swap_pending", swap_pending, mpend);
        chk("swap_done", swap_done, mdone);
        chk("front_fb", front_fb, mfront);
    endtask

    task automatic model_step();
        bit fire;
        int idx;
        fire  = e_tick && (e_row == 4'd15) && (mpend || swap_req) && (clr_left == 0);
        mdone = fire;
        if (fire) mfront = mback;
        mpend = (mpend || swap_req) && !fire;
        if (clr_left > 0) begin
            mback[(16 - clr_left) * 16 +: 16] = '0;
            clr_left--;
        end else if (clear) begin
            clr_left = 16;
        end else if (e_gnt == 2'b01) begin
            idx = int'(addr0[7:4]) * 16 + int'(addr0[3:0]);
            mback[idx] = data0;
            mptr = 1'b1;
        end else if (e_gnt == 2'b10) begin
            idx = int'(addr1[7:4]) * 16 + int'(addr1[3:0]);
            mback[idx] = data1;
            mptr = 1'b0;
        end
        cyc++;
    endtask

    // Inputs are set just after a falling edge; this samples, steps the model, returns at next falling edge.
    task automatic cycle();
        #1;
        check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req = 2'b00; clear = 1'b0; swap_req = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; data0 = 1'b0; data1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_front_fb", front_fb, '0);
        chk("rst_scan_row", scan_row, '0);
        chk("rst_busy", busy, '0);
        chk("rst_gnt", gnt, '0);
        chk("rst_scan_tick", scan_tick, '0);
        chk("rst_swap_pending", swap_pending, '0);
        chk("rst_swap_done", swap_done, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses swap_req and waits (bounded) for swap_done; leaves s_front holding the new front buffer.
    task automatic swap_and_wait(input string name);
        bit seen;
        seen = 1'b0;
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        for (int i = 0; i < 16 * D + 8 && !seen; i++) begin
            cycle();
            if (s_done) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  found, busy_n, row_prev, tick_prev;
        bit  seen;
        logic [1:0] seq [4];

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // First tick lands on cycle 3 after release.
        found = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_tick && found < 0) found = i;
        end
        chk("first_tick_cycle", found, 3);

        // Contention: both ask every cycle with fresh addresses after each grant.
        req = 2'b11; addr0 = 8'h11; addr1 = 8'h21; data0 = 1'b1; data1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = s_gnt;
            if (s_gnt[0]) addr0 = 8'h12;
            if (s_gnt[1]) addr1 = 8'h22;
        end
        chk("contention_gnt0", seq[0], 2'b01);
        chk("contention_gnt1", seq[1], 2'b10);
        chk("contention_gnt2", seq[2], 2'b01);
        chk("contention_gnt3", seq[3], 2'b10);
        idle_inputs();
        swap_and_wait("contention_swap_done");
        chk("contention_pixels", {s_front[17], s_front[18], s_front[33], s_front[34]}, 4'hf);

        // Basic swap of pixel (3,5) = bit 53.
        req = 2'b01; addr0 = 8'h35; data0 = 1'b1;
        cycle();
        idle_inputs();
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        seen = 1'b0; row_prev = -1; tick_prev = -1;
        for (int i = 0; i < 16 * D + 8 && !seen; i++) begin
            row_prev = int'(s_row); tick_prev = int'(s_tick);
            cycle();
            if (s_front[53]) seen = 1'b1;
        end
        chk("swap_bit53_seen", seen, 1'b1);
        chk("swap_prev_row", row_prev, 15);
        chk("swap_prev_tick", tick_prev, 1);
        chk("swap_done_with_front", s_done, 1'b1);

        // Clear with requester 0 held.
        req = 2'b01; addr0 = 8'h40; data0 = 1'b1; clear = 1'b1;
        cycle();
        chk("clear_start_gnt", s_gnt, 2'b00);
        clear = 1'b0;
        busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            if (s_busy) begin
                busy_n++;
                chk("clear_gnt_blocked", s_gnt, 2'b00);
            end else begin
                chk("clear_exit_gnt", s_gnt, 2'b01);
                seen = 1'b1;
            end
        end
        chk("clear_busy_cycles", busy_n, 16);
        idle_inputs();
        swap_and_wait("clear_swap_done");
        chk("clear_back_contents", s_front, 256'd1 << 64);

        // Swap and a granted write on the same boundary cycle.
        for (int i = 0; i < 100 && !(((cyc % D) == D - 1) && (((cyc / D) % 16) == 15)); i++) cycle();
        swap_req = 1'b1; req = 2'b01; addr0 = 8'h99; data0 = 1'b1;
        cycle();
        chk("same_cycle_gnt", s_gnt, 2'b01);
        idle_inputs();
        cycle();
        chk("same_cycle_done", s_done, 1'b1);
        chk("same_cycle_excluded", s_front[153], 1'b0);
        swap_and_wait("same_cycle_next_done");
        chk("same_cycle_next_included", s_front[153], 1'b1);

        // Reset part-way through a clear.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (7) cycle();
        do_reset();
        cycle();
        chk("post_reset_busy", s_busy, 1'b0);
        req = 2'b01; addr0 = 8'h01; data0 = 1'b0;
        cycle();
        chk("post_reset_gnt", s_gnt, 2'b01);
        idle_inputs();
        swap_and_wait("post_reset_swap_done");
        chk("post_reset_back_zero", s_front, '0);

        // Randomized traffic obeying the hold-until-granted rule.
        for (int i = 0; i < 2500; i++) begin
            if (!(req[0] && !e_gnt[0])) begin
                req[0] = 1'($urandom_range(0, 1));
                addr0  = 8'($urandom_range(0, 255));
                data0  = 1'($urandom_range(0, 1));
            end
            if (!(req[1] && !e_gnt[1])) begin
                req[1] = 1'($urandom_range(0, 1));
                addr1  = 8'($urandom_range(0, 255));
                data1  = 1'($urandom_range(0, 1));
            end
            clear    = ($urandom_range(0, 39) == 0);
            swap_req = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
